// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order instruction fetch queue between the fetch unit and decode.
// Each accepted memory request reserves a ring-buffer entry tagged with its PC.
// In-order responses fill entries, and decode drains the head over valid/ready.
// A flush discards all entries. Responses still owed to flushed requests are
// counted in a drop counter, so they are thrown away when they return.
//
// Handshake semantics (all three interfaces): a transfer happens on a rising
// clock edge where valid and ready are both high; valid never depends on the
// same-side ready; payload is only meaningful while valid is high.
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [XLEN-1:0]          io_pc,
  input  logic                     io_flush,
  output logic                     io_imem_req_valid,
  input  logic                     io_imem_req_ready,
  output logic [XLEN-1:0]          io_imem_req_addr,
  input  logic                     io_imem_resp_valid,
  input  logic [XLEN-1:0]          io_imem_resp_data,
  output logic                     io_stall,
  output logic                     io_deq_valid,
  input  logic                     io_deq_ready,
  output logic [XLEN-1:0]          io_deq_inst,
  output logic [XLEN-1:0]          io_deq_pc,
  output logic [$clog2(DEPTH):0]   io_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  // Occupancy plus drop can reach DEPTH, so compare in one extra bit.
  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [IW-1:0] idx_t;

  // Pointers carry an extra wrap bit; entries are indexed by the low bits.
  ptr_t alloc_q, alloc_d;
  ptr_t fill_q,  fill_d;
  ptr_t head_q,  head_d;
  ptr_t drop_q,  drop_d;
  logic [DEPTH-1:0] filled_q, filled_d;

  // Entry payload; written only when an entry is allocated or filled.
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [XLEN-1:0] inst_q [DEPTH];

  idx_t        alloc_idx, fill_idx, head_idx;
  ptr_t        used_entries;
  ptr_t        outstanding;
  logic [PW:0] used_total;
  logic        has_free;
  logic        issue;
  logic        resp_drop;
  logic        resp_fill;
  logic        deq_fire;

  assign alloc_idx = alloc_q[IW-1:0];
  assign fill_idx  = fill_q[IW-1:0];
  assign head_idx  = head_q[IW-1:0];

  // Allocated entries and requests not yet answered.
  assign used_entries = alloc_q - head_q;
  assign outstanding  = alloc_q - fill_q;

  // Slots owed to flushed responses are unavailable until those responses drain.
  assign used_total = {1'b0, used_entries} + {1'b0, drop_q};
  assign has_free   = (used_total < DEPTH_W);

  // No request on a flush cycle: io_pc is still the stale pre-redirect PC.
  assign io_imem_req_valid = has_free && !io_flush;
  assign io_imem_req_addr  = io_pc;
  assign issue             = io_imem_req_valid && io_imem_req_ready;

  // The PC advances exactly once per accepted request, or is redirected on flush.
  assign io_stall = !io_flush && !issue;

  // Responses are classified: owed to a flushed request, filling, or spurious.
  assign resp_drop = io_imem_resp_valid && (drop_q != '0);
  assign resp_fill = io_imem_resp_valid && (drop_q == '0) && (fill_q != alloc_q);

  // Head presented to decode with zero latency from the entry storage.
  assign io_deq_valid = filled_q[head_idx] && (head_q != alloc_q) && !io_flush;
  assign io_deq_inst  = inst_q[head_idx];
  assign io_deq_pc    = pc_q[head_idx];
  assign deq_fire     = io_deq_valid && io_deq_ready;

  assign io_count = used_entries;

  // Next-state for pointers, filled bits and the drop counter.
  always_comb begin
    alloc_d  = alloc_q;
    fill_d   = fill_q;
    head_d   = head_q;
    drop_d   = drop_q;
    filled_d = filled_q;
    if (io_flush) begin
      // Every request not yet answered becomes owed. A response arriving this
      // cycle answers one of them, whether it would have filled or been dropped.
      alloc_d  = '0;
      fill_d   = '0;
      head_d   = '0;
      filled_d = '0;
      drop_d   = drop_q + outstanding - PW'(resp_fill) - PW'(resp_drop);
    end else begin
      // Allocate, fill and dequeue touch three different slots when they coincide.
      if (issue) begin
        alloc_d             = alloc_q + 1'b1;
        filled_d[alloc_idx] = 1'b0;
      end
      if (resp_drop) begin
        drop_d = drop_q - 1'b1;
      end
      if (resp_fill) begin
        fill_d             = fill_q + 1'b1;
        filled_d[fill_idx] = 1'b1;
      end
      if (deq_fire) begin
        head_d             = head_q + 1'b1;
        filled_d[head_idx] = 1'b0;
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      alloc_q  <= '0;
      fill_q   <= '0;
      head_q   <= '0;
      drop_q   <= '0;
      filled_q <= '0;
    end else begin
      alloc_q  <= alloc_d;
      fill_q   <= fill_d;
      head_q   <= head_d;
      drop_q   <= drop_d;
      filled_q <= filled_d;
    end
  end

  // Entry payload: PC captured at issue, instruction captured at fill.
  always_ff @(posedge clock) begin
    if (!reset && !io_flush) begin
      if (issue) begin
        pc_q[alloc_idx] <= io_pc;
      end
      if (resp_fill) begin
        inst_q[fill_idx] <= io_imem_resp_data;
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: cycle table of directed scenarios plus a random phase.
// A scoreboard queue holds {pc, inst}. Each accepted request pushes an entry,
// each dequeue pops one, and a flush clears the queue.
// A behavioural memory returns in-order responses after a per-request latency.
module tb_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic            io_flush;
  logic [XLEN-1:0] io_pc;
  logic            io_imem_req_valid;
  logic            io_imem_req_ready;
  logic [XLEN-1:0] io_imem_req_addr;
  logic            io_imem_resp_valid;
  logic [XLEN-1:0] io_imem_resp_data;
  logic            io_stall;
  logic            io_deq_valid;
  logic            io_deq_ready;
  logic [XLEN-1:0] io_deq_inst;
  logic [XLEN-1:0] io_deq_pc;
  logic [CW-1:0]   io_count;

  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_pc              (io_pc),
    .io_flush           (io_flush),
    .io_imem_req_valid  (io_imem_req_valid),
    .io_imem_req_ready  (io_imem_req_ready),
    .io_imem_req_addr   (io_imem_req_addr),
    .io_imem_resp_valid (io_imem_resp_valid),
    .io_imem_resp_data  (io_imem_resp_data),
    .io_stall           (io_stall),
    .io_deq_valid       (io_deq_valid),
    .io_deq_ready       (io_deq_ready),
    .io_deq_inst        (io_deq_inst),
    .io_deq_pc          (io_deq_pc),
    .io_count           (io_count)
  );

  // ---------------- vectors, memory model, scoreboard ----------------
  typedef struct {
    logic        rst;
    int          lat;
    logic        fl;
    logic        rr;
    logic        dr;
    logic        sp;
    logic [31:0] redir;
    logic        rv;
    logic        st;
    logic        dv;
    logic [CW-1:0] cnt;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  vec_t        vecs[$];
  mem_t        memq[$];
  logic [63:0] exp_q[$];

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          last_due = 0;
  logic [31:0] pc_m     = '0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[7:0], pc[31:8]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic add(input logic rst, input int l, input logic fl, input logic rr,
                     input logic dr, input logic sp, input logic [31:0] redir,
                     input logic rv, input logic st, input logic dv, input logic [CW-1:0] cnt);
    vec_t v;
    v = '{rst, l, fl, rr, dr, sp, redir, rv, st, dv, cnt};
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset              = 1'b1;
    io_flush           = 1'b0;
    io_imem_req_ready  = 1'b0;
    io_deq_ready       = 1'b0;
    io_imem_resp_valid = 1'b0;
    io_imem_resp_data  = '0;
    io_pc              = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    memq.delete();
    exp_q.delete();
    cyc      = 0;
    last_due = 0;
    pc_m     = '0;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, update models, advance.
  task automatic step(input logic fl, input logic rr, input logic dr, input logic sp,
                      input logic [31:0] redir, input logic use_exp,
                      input logic rv, input logic st, input logic dv, input logic [CW-1:0] cnt);
    logic        from_mem;
    logic        acc;
    logic        dq;
    logic        stl;
    logic [63:0] e;
    int          due;
    io_flush          = fl;
    io_imem_req_ready = rr;
    io_deq_ready      = dr;
    io_pc             = pc_m;
    from_mem = (memq.size() > 0) && (memq[0].due <= cyc);
    if (from_mem) begin
      io_imem_resp_valid = 1'b1;
      io_imem_resp_data  = inst_of(memq[0].addr);
    end else if (sp) begin
      io_imem_resp_valid = 1'b1;
      io_imem_resp_data  = 32'h0BAD_C0DE;
    end else begin
      io_imem_resp_valid = 1'b0;
      io_imem_resp_data  = '0;
    end
    #1;
    chk("req_addr", io_imem_req_addr, pc_m);
    if (use_exp) begin
      chk("req_valid", io_imem_req_valid, rv);
      chk("stall", io_stall, st);
      chk("deq_valid", io_deq_valid, dv);
      chk("count", io_count, cnt);
    end else begin
      chk("stall_rule", io_stall, !fl && !(io_imem_req_valid && rr));
      chk("count_model", io_count, exp_q.size());
    end
    acc = io_imem_req_valid && rr;
    dq  = io_deq_valid && dr;
    stl = io_stall;
    if (dq) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL deq_unexpected cycle=%0d actual=valid_pc_%h required=no_entry", cyc, io_deq_pc);
      end else begin
        e = exp_q.pop_front();
        chk("deq_pc", io_deq_pc, e[63:32]);
        chk("deq_inst", io_deq_inst, e[31:0]);
      end
    end
    if (fl) exp_q.delete();
    if (acc) begin
      exp_q.push_back({pc_m, inst_of(pc_m)});
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{pc_m, due});
    end
    if (from_mem) void'(memq.pop_front());
    if (fl) pc_m = redir;
    else if (!stl) pc_m = pc_m + 32'd4;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // ---------------- test ----------------
  initial begin
    // rst lat fl rr dr sp redir       rv st dv cnt
    // A: streaming, latency 1, everything ready
    add(1, 1, 0, 1, 1, 0, 32'h0,   1, 0, 0, 0);
    add(0, 1, 0, 1, 1, 0, 32'h0,   1, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 1, 1, 0, 32'h0, 1, 0, 1, 2);
    // B: decode blocked until full, one dequeue frees one slot
    add(1, 1, 0, 1, 0, 0, 32'h0,   1, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 32'h0,   1, 0, 0, 1);
    add(0, 1, 0, 1, 0, 0, 32'h0,   1, 0, 1, 2);
    add(0, 1, 0, 1, 0, 0, 32'h0,   1, 0, 1, 3);
    add(0, 1, 0, 1, 0, 0, 32'h0,   0, 1, 1, 4);
    add(0, 1, 0, 1, 1, 0, 32'h0,   0, 1, 1, 4);
    add(0, 1, 0, 1, 0, 0, 32'h0,   1, 0, 1, 3);
    add(0, 1, 0, 1, 0, 0, 32'h0,   0, 1, 1, 4);
    add(0, 1, 0, 1, 1, 0, 32'h0,   0, 1, 1, 4);
    // C: memory not ready for 3 cycles
    for (int i = 0; i < 3; i++) add(i == 0, 1, 0, 0, 1, 0, 32'h0, 1, 1, 0, 0);
    add(0, 1, 0, 1, 1, 0, 32'h0,   1, 0, 0, 0);
    add(0, 1, 0, 1, 1, 0, 32'h0,   1, 0, 0, 1);
    add(0, 1, 0, 1, 1, 0, 32'h0,   1, 0, 1, 2);
    // D: 3 outstanding at latency 5, flush to 0x100
    add(1, 5, 0, 1, 1, 0, 32'h0,   1, 0, 0, 0);
    add(0, 5, 0, 1, 1, 0, 32'h0,   1, 0, 0, 1);
    add(0, 5, 0, 1, 1, 0, 32'h0,   1, 0, 0, 2);
    add(0, 5, 1, 1, 1, 0, 32'h100, 0, 0, 0, 3);
    add(0, 5, 0, 1, 1, 0, 32'h0,   1, 0, 0, 0);
    add(0, 5, 0, 1, 1, 0, 32'h0,   0, 1, 0, 1);
    add(0, 5, 0, 1, 1, 0, 32'h0,   1, 0, 0, 1);
    add(0, 5, 0, 1, 1, 0, 32'h0,   1, 0, 0, 2);
    add(0, 5, 0, 1, 1, 0, 32'h0,   1, 0, 0, 3);
    add(0, 5, 0, 1, 1, 0, 32'h0,   0, 1, 0, 4);
    add(0, 5, 0, 1, 1, 0, 32'h0,   0, 1, 1, 4);
    add(0, 5, 0, 1, 1, 0, 32'h0,   1, 0, 0, 3);
    add(0, 5, 0, 1, 1, 0, 32'h0,   0, 1, 1, 4);
    // E: flush coincides with a response, 2 outstanding
    add(1, 2, 0, 1, 1, 0, 32'h0,   1, 0, 0, 0);
    add(0, 2, 0, 1, 1, 0, 32'h0,   1, 0, 0, 1);
    add(0, 2, 1, 1, 1, 0, 32'h200, 0, 0, 0, 2);
    add(0, 2, 0, 1, 1, 0, 32'h0,   1, 0, 0, 0);
    add(0, 2, 0, 1, 1, 0, 32'h0,   1, 0, 0, 1);
    add(0, 2, 0, 1, 1, 0, 32'h0,   1, 0, 0, 2);
    add(0, 2, 0, 1, 1, 0, 32'h0,   1, 0, 1, 3);
    // F: spurious response with nothing outstanding
    add(1, 1, 0, 0, 1, 1, 32'h0,   1, 1, 0, 0);
    add(0, 1, 0, 0, 1, 0, 32'h0,   1, 1, 0, 0);
    add(0, 1, 0, 1, 1, 0, 32'h0,   1, 0, 0, 0);
    add(0, 1, 0, 1, 1, 0, 32'h0,   1, 0, 0, 1);
    add(0, 1, 0, 1, 1, 0, 32'h0,   1, 0, 1, 2);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      lat = vecs[i].lat;
      step(vecs[i].fl, vecs[i].rr, vecs[i].dr, vecs[i].sp, vecs[i].redir, 1'b1,
           vecs[i].rv, vecs[i].st, vecs[i].dv, vecs[i].cnt);
    end

    // Random phase: random readiness, latency and flushes; scoreboard and count model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(1, 6);
      step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           1'b0, 32'($urandom_range(0, 16383)) << 2, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    end

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
